// File: rtl/tmds_decode_align_if.sv
// Per-channel bus between the 10:1 deserializer side and the TMDS decoder/aligner.
interface tmds_decode_align_if;
    logic [9:0] iDATA;
    logic [7:0] oDATA;
    logic [1:0] oCTL;
    logic       oBLANK;
    logic       oLOCKED;
    logic [3:0] oOFFSET;

    modport master (output iDATA, input oDATA, oCTL, oBLANK, oLOCKED, oOFFSET);
    modport slave  (input iDATA, output oDATA, oCTL, oBLANK, oLOCKED, oOFFSET);
endinterface

// File: rtl/tmds_decode_align.sv
// TMDS receive channel: bit-slips raw deserializer words onto the symbol boundary
// using blanking control tokens, then decodes aligned symbols to pixel/control data.
module tmds_decode_align #(
    parameter int MISS_LIMIT = 16,
    parameter int LOCK_CNT   = 8,
    parameter int LOSS_LIMIT = 4096
) (
    input  logic               iCLK,
    input  logic               iRESET,
    tmds_decode_align_if.slave bus
);
    localparam int MissW = $clog2(MISS_LIMIT + 1);
    localparam int RunW  = $clog2(LOCK_CNT + 1);
    localparam int LossW = $clog2(LOSS_LIMIT + 1);

    localparam logic [MissW-1:0] MissLast = MissW'(MISS_LIMIT - 1);
    localparam logic [MissW-1:0] MissOne  = MissW'(1);
    localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_CNT - 1);
    localparam logic [RunW-1:0]  RunOne   = RunW'(1);
    localparam logic [LossW-1:0] LossLast = LossW'(LOSS_LIMIT - 1);
    localparam logic [LossW-1:0] LossOne  = LossW'(1);

    typedef enum logic {SEARCH, LOCKED} alignState_t;

    alignState_t      state, stateNext;
    logic [3:0]       offset, offsetNext;
    logic [MissW-1:0] missCnt, missCntNext;
    logic [RunW-1:0]  runCnt, runCntNext;
    logic [LossW-1:0] lossCnt, lossCntNext;

    logic [9:0]  prevWord;
    logic [19:0] pair;
    logic [9:0]  window;
    logic        tokenHit;
    logic [1:0]  tokenCtl;

    logic [9:0] s1Window;
    logic       s1Hit;
    logic [1:0] s1Ctl;
    logic [7:0] dWord;
    logic [7:0] decoded;

    logic [7:0] dataQ;
    logic [1:0] ctlQ;
    logic       blankQ;

    // The previous word forms the low half, so offset k skips the k earliest bits.
    assign pair   = {bus.iDATA, prevWord};
    assign window = 10'(pair >> offset);

    always_comb begin
        tokenHit = 1'b1;
        tokenCtl = 2'd0;
        case (window)
            10'h354: tokenCtl = 2'd0;
            10'h0AB: tokenCtl = 2'd1;
            10'h154: tokenCtl = 2'd2;
            10'h2AB: tokenCtl = 2'd3;
            default: tokenHit = 1'b0;
        endcase
    end

    always_comb begin
        stateNext   = state;
        offsetNext  = offset;
        missCntNext = missCnt;
        runCntNext  = runCnt;
        lossCntNext = lossCnt;
        case (state)
            SEARCH: begin
                lossCntNext = '0;
                if (tokenHit) begin
                    missCntNext = '0;
                    if (runCnt == RunLast) begin
                        stateNext  = LOCKED;
                        runCntNext = '0;
                    end else begin
                        runCntNext = runCnt + RunOne;
                    end
                end else begin
                    runCntNext = '0;
                    if (missCnt == MissLast) begin
                        missCntNext = '0;
                        offsetNext  = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    end else begin
                        missCntNext = missCnt + MissOne;
                    end
                end
            end
            LOCKED: begin
                runCntNext  = '0;
                missCntNext = '0;
                // A token on the limit cycle wins, so only an unbroken drought drops lock.
                if (tokenHit) begin
                    lossCntNext = '0;
                end else if (lossCnt == LossLast) begin
                    stateNext   = SEARCH;
                    lossCntNext = '0;
                end else begin
                    lossCntNext = lossCnt + LossOne;
                end
            end
            default: stateNext = SEARCH;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= SEARCH;
            offset   <= 4'd0;
            missCnt  <= '0;
            runCnt   <= '0;
            lossCnt  <= '0;
            prevWord <= 10'd0;
        end else begin
            state    <= stateNext;
            offset   <= offsetNext;
            missCnt  <= missCntNext;
            runCnt   <= runCntNext;
            lossCnt  <= lossCntNext;
            prevWord <= bus.iDATA;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s1Window <= 10'd0;
            s1Hit    <= 1'b0;
            s1Ctl    <= 2'd0;
        end else begin
            s1Window <= window;
            s1Hit    <= tokenHit;
            s1Ctl    <= tokenCtl;
        end
    end

    always_comb begin
        decoded    = '0;
        dWord      = s1Window[9] ? ~s1Window[7:0] : s1Window[7:0];
        decoded[0] = dWord[0];
        for (int i = 1; i < 8; i++) begin
            decoded[i] = s1Window[8] ? (dWord[i] ^ dWord[i-1]) : ~(dWord[i] ^ dWord[i-1]);
        end
    end

    // Output stage: unlocked forces blanking; data symbols keep the last control value.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            dataQ  <= 8'd0;
            ctlQ   <= 2'd0;
            blankQ <= 1'b1;
        end else if (state != LOCKED) begin
            dataQ  <= 8'd0;
            ctlQ   <= 2'd0;
            blankQ <= 1'b1;
        end else if (s1Hit) begin
            dataQ  <= 8'd0;
            ctlQ   <= s1Ctl;
            blankQ <= 1'b1;
        end else begin
            dataQ  <= decoded;
            blankQ <= 1'b0;
        end
    end

    assign bus.oDATA   = dataQ;
    assign bus.oCTL    = ctlQ;
    assign bus.oBLANK  = blankQ;
    assign bus.oLOCKED = (state == LOCKED);
    assign bus.oOFFSET = offset;
endmodule
